hs_sync_tx: RTL and testbench

HS_SYNC_TX -- requirements
Module: hs_sync_tx

---
 rtl/hs_sync_pkg.sv | 32 +++
 rtl/hs_sync_tx_synchronizer.sv | 43 ++++
 rtl/hs_sync_tx.sv | 169 ++++++++++++++++
 tb/tb_hs_sync_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_sync_pkg.sv
// ---------------------------------------------------------------------------
// hs_sync_pkg
//
// Purpose:
//     Types and constants for the four-phase clock-domain-crossing handshake.
//     The transmit side uses them today. The matching receive side will
//     import the same package so that both ends agree on state encoding and
//     counter width.
//
// Contents:
//     WaitCntWidth - width of the per-phase wait counter
//     waitCnt_t    - wait counter type
//     hsState_e    - 2-bit handshake FSM state encoding
// ---------------------------------------------------------------------------
package hs_sync_pkg;

    localparam int unsigned WaitCntWidth = 16;

    typedef logic [WaitCntWidth-1:0] waitCnt_t;

    // IDLE   : no transfer in flight; may accept a payload
    // REQ_HI : request raised, waiting for the synchronized ack to rise
    // REQ_LO : request dropped, waiting for the synchronized ack to fall
    // ERR    : an ack phase timed out; waiting for software to clear
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ_HI = 2'b01,
        REQ_LO = 2'b10,
        ERR    = 2'b11
    } hsState_e;

endpackage : hs_sync_pkg

// File: rtl/hs_sync_tx_synchronizer.sv
// ---------------------------------------------------------------------------
// Synchronizer
//
// Purpose:
//     A plain multi-flop synchronizer that brings a level signal into the
//     clk_i domain. Each bit is synchronized on its own, so it is only safe
//     for single-bit levels or for buses that are known to be stable.
//
// Parameters:
//     Width      - number of bits synchronized
//     NUM_Stages - flop chain depth (2 or more)
//
// Ports:
//     clk_i   in   destination-domain clock
//     rst_ni  in   asynchronous active-low reset; clears every stage
//     data_i  in   asynchronous input level(s)
//     data_o  out  synchronized level(s), taken from the last stage
// ---------------------------------------------------------------------------
module Synchronizer #(
    parameter int Width      = 1,
    parameter int NUM_Stages = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [NUM_Stages-1:0][Width-1:0] stages_q;

    // Shift the asynchronous level through the chain. Stage 0 is the only
    // flop that can go metastable. Later stages give it time to resolve.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stages_q <= '0;
        end else begin
            stages_q <= {stages_q[NUM_Stages-2:0], data_i};
        end
    end

    assign data_o = stages_q[NUM_Stages-1];

endmodule : Synchronizer

// File: rtl/hs_sync_tx.sv
// ---------------------------------------------------------------------------
// hs_sync_tx
//
// Purpose:
//     Transmit side of a four-phase request/acknowledge clock-domain crossing.
//     A payload accepted from the local producer is registered onto Tx_data
//     and announced with Tx_req. The destination answers on Ack_async. Ack is
//     synchronized into this domain, and the request is retired once ack has
//     risen and fallen again. Each ack phase is guarded by a wait counter. A
//     phase that takes too long parks the block in an error state until it is
//     cleared.
//
// Parameters:
//     NUM_Stages - ack synchronizer depth (2..8)
//     Width      - payload width in bits
//     TIMEOUT    - maximum cycles to wait in either ack phase (1..65535)
//
// Ports:
//     CLK        in   source-domain clock
//     Reset      in   asynchronous active-low reset (taken pre-synchronized)
//     Src_data   in   payload from the local producer
//     Src_valid  in   producer has a payload
//     Src_ready  out  block can accept a payload this cycle
//     Tx_data    out  registered payload crossing the domain boundary
//     Tx_req     out  four-phase request level
//     Ack_async  in   four-phase acknowledge level, asynchronous to CLK
//     Done       out  one-cycle pulse when a handshake completes
//     Err        out  sticky timeout flag
//     Err_clr    in   clears Err and leaves the error state
// ---------------------------------------------------------------------------
module hs_sync_tx
    import hs_sync_pkg::*;
#(
    parameter int NUM_Stages = 2,
    parameter int Width      = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [Width-1:0] Src_data,
    input  logic             Src_valid,
    output logic             Src_ready,
    output logic [Width-1:0] Tx_data,
    output logic             Tx_req,
    input  logic             Ack_async,
    output logic             Done,
    output logic             Err,
    input  logic             Err_clr
);

    localparam waitCnt_t TimeoutCnt = waitCnt_t'(TIMEOUT);

    hsState_e   state_q,   state_d;
    waitCnt_t   waitCnt_q, waitCnt_d;
    logic [Width-1:0] txData_q, txData_d;
    logic       txReq_q,   txReq_d;
    logic       done_q,    done_d;
    logic       err_q,     err_d;
    logic       srcReady;
    logic       ackSync;
    logic       timedOut;

    // Ack_async goes straight into the synchronizer with no logic in front
    // of it, so the first flop sees a clean, glitch-free level.
    Synchronizer #(
        .Width      (1),
        .NUM_Stages (NUM_Stages)
    ) u_ackSync (
        .clk_i  (CLK),
        .rst_ni (Reset),
        .data_i (Ack_async),
        .data_o (ackSync)
    );

    assign timedOut = (waitCnt_q == TimeoutCnt);

    // Next-state and output decode. In the two wait states the ack check
    // comes before the timeout check. If ack arrives on the same cycle the
    // counter expires, the handshake still proceeds. A new payload is
    // offered only when the previous ack has fully returned low, so a stale
    // high ack can never be mistaken for the answer to the next request.
    always_comb begin
        state_d  = state_q;
        txData_d = txData_q;
        txReq_d  = txReq_q;
        done_d   = 1'b0;
        err_d    = err_q;
        srcReady = 1'b0;

        unique case (state_q)
            IDLE: begin
                srcReady = ~ackSync;
                if (Src_valid && srcReady) begin
                    txData_d = Src_data;
                    txReq_d  = 1'b1;
                    state_d  = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ackSync) begin
                    txReq_d = 1'b0;
                    state_d = REQ_LO;
                end else if (timedOut) begin
                    txReq_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            REQ_LO: begin
                if (!ackSync) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (timedOut) begin
                    txReq_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            ERR: begin
                if (Err_clr) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The wait counter measures time spent in the current ack phase only.
    // It restarts on every state change and never runs past TIMEOUT, because
    // reaching TIMEOUT always forces a state change.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (state_d != state_q) begin
            waitCnt_d = '0;
        end else if ((state_q == REQ_HI) || (state_q == REQ_LO)) begin
            waitCnt_d = waitCnt_q + waitCnt_t'(1);
        end
    end

    // State register. Reset abandons any transfer in flight and produces no
    // Done pulse for it.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            txData_q  <= '0;
            txReq_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            txData_q  <= txData_d;
            txReq_q   <= txReq_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign Src_ready = srcReady;
    assign Tx_data   = txData_q;
    assign Tx_req    = txReq_q;
    assign Done      = done_q;
    assign Err       = err_q;

endmodule : hs_sync_tx

// File: tb/tb_hs_sync_tx.sv
// ---------------------------------------------------------------------------
// tb_hs_sync_tx
//
// Purpose:
//     Directed self-checking bench for hs_sync_tx, built with NUM_Stages=2,
//     Width=8 and TIMEOUT=10. Ack_async is either an immediate echo of
//     Tx_req, which models a destination that responds at once, or a level
//     driven directly by the stimulus.
// ---------------------------------------------------------------------------
module tb_hs_sync_tx;

    logic       clock;
    logic       resetN;
    logic [7:0] srcData;
    logic       srcValid;
    logic       srcReady;
    logic [7:0] txData;
    logic       txReq;
    logic       ackAsync;
    logic       done;
    logic       err;
    logic       errClr;

    logic       echoEn;
    logic       ackForce;

    int checks;
    int failures;

    hs_sync_tx #(
        .NUM_Stages (2),
        .Width      (8),
        .TIMEOUT    (10)
    ) dut (
        .CLK       (clock),
        .Reset     (resetN),
        .Src_data  (srcData),
        .Src_valid (srcValid),
        .Src_ready (srcReady),
        .Tx_data   (txData),
        .Tx_req    (txReq),
        .Ack_async (ackAsync),
        .Done      (done),
        .Err       (err),
        .Err_clr   (errClr)
    );

    // Destination model: either echo the request straight back or follow
    // the level set by the stimulus.
    assign ackAsync = echoEn ? txReq : ackForce;

    // 10 time-unit clock; rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges, then settle 1 unit past the edge so that the
    // registered outputs are stable for sampling and inputs can be changed.
    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        srcValid = valid;
        srcData  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] payload [3];
        int         doneCnt;
        int         idx;
        logic       accepting;

        payload[0] = 8'h01;
        payload[1] = 8'h02;
        payload[2] = 8'h03;
        checks     = 0;
        failures   = 0;
        echoEn     = 1'b0;
        ackForce   = 1'b0;
        errClr     = 1'b0;
        applyStimulus(1'b0, 8'h00);
        resetN     = 1'b0;

        // ---- reset state ----
        #2;
        checkOutput("rst_txreq",    32'(txReq),    32'h0);
        checkOutput("rst_txdata",   32'(txData),   32'h00);
        checkOutput("rst_done",     32'(done),     32'h0);
        checkOutput("rst_err",      32'(err),      32'h0);
        checkOutput("rst_srcready", 32'(srcReady), 32'h1);
        #10;
        resetN = 1'b1;
        waitCycles(2);

        // ---- reset in the middle of REQ_HI abandons the transfer ----
        applyStimulus(1'b1, 8'h5A);
        waitCycles(1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("midrst_pre_txdata", 32'(txData), 32'h5A);
        checkOutput("midrst_pre_txreq",  32'(txReq),  32'h1);
        waitCycles(1);
        resetN = 1'b0;
        #1;
        checkOutput("midrst_txreq",    32'(txReq),    32'h0);
        checkOutput("midrst_txdata",   32'(txData),   32'h00);
        checkOutput("midrst_srcready", 32'(srcReady), 32'h1);
        checkOutput("midrst_done",     32'(done),     32'h0);
        #2;
        resetN  = 1'b1;
        doneCnt = 0;
        for (int k = 0; k < 6; k++) begin
            waitCycles(1);
            if (done) doneCnt++;
        end
        checkOutput("midrst_no_done", 32'(doneCnt), 32'd0);

        // ---- single handshake with an immediately responding destination ----
        echoEn = 1'b1;
        applyStimulus(1'b1, 8'hA5);
        waitCycles(1);
        applyStimulus(1'b0, 8'h00);
        doneCnt = 0;
        for (int k = 1; k <= 7; k++) begin
            waitCycles(1);
            if (done) doneCnt++;
            checkOutput($sformatf("hs_txdata_c%0d", k), 32'(txData), 32'hA5);
            if (k <= 6) begin
                checkOutput($sformatf("hs_srcready_c%0d", k), 32'(srcReady),
                            (k == 6) ? 32'h1 : 32'h0);
                checkOutput($sformatf("hs_done_c%0d", k), 32'(done),
                            (k == 6) ? 32'h1 : 32'h0);
            end
        end
        checkOutput("hs_done_count", 32'(doneCnt), 32'd1);

        // ---- Src_data churn while busy must not reach Tx_data ----
        applyStimulus(1'b1, 8'h96);
        waitCycles(1);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 8'(k * 37 + 3));
            waitCycles(1);
            checkOutput($sformatf("churn_txdata_c%0d", k), 32'(txData), 32'h96);
        end
        applyStimulus(1'b0, 8'h00);
        waitCycles(1);
        checkOutput("churn_done",       32'(done),   32'h1);
        checkOutput("churn_txdata_end", 32'(txData), 32'h96);

        // ---- back-to-back payloads with Src_valid held high ----
        idx     = 0;
        doneCnt = 0;
        applyStimulus(1'b1, payload[0]);
        for (int cyc = 0; cyc < 60 && doneCnt < 3; cyc++) begin
            accepting = srcReady && srcValid;
            waitCycles(1);
            if (done) begin
                checkOutput($sformatf("b2b_done_data%0d", doneCnt), 32'(txData),
                            32'(payload[doneCnt]));
                doneCnt++;
            end
            if (accepting) begin
                checkOutput($sformatf("b2b_load%0d", idx), 32'(txData), 32'(payload[idx]));
                idx++;
                if (idx < 3) applyStimulus(1'b1, payload[idx]);
                else         applyStimulus(1'b0, 8'h00);
            end
        end
        for (int k = 0; k < 8; k++) begin
            waitCycles(1);
            if (done) doneCnt++;
        end
        checkOutput("b2b_done_count",   32'(doneCnt), 32'd3);
        checkOutput("b2b_accept_count", 32'(idx),     32'd3);

        // ---- timeout in REQ_HI, then recovery through Err_clr ----
        echoEn   = 1'b0;
        ackForce = 1'b0;
        errClr   = 1'b1;
        applyStimulus(1'b1, 8'hC3);
        checkOutput("errclr_idle_ready", 32'(srcReady), 32'h1);
        waitCycles(1);
        errClr = 1'b0;
        applyStimulus(1'b0, 8'h00);
        checkOutput("to_load_txreq", 32'(txReq), 32'h1);
        checkOutput("to_load_err",   32'(err),   32'h0);
        waitCycles(10);
        checkOutput("to_c10_err",   32'(err),   32'h0);
        checkOutput("to_c10_txreq", 32'(txReq), 32'h1);
        waitCycles(1);
        checkOutput("to_c11_err",      32'(err),      32'h1);
        checkOutput("to_c11_txreq",    32'(txReq),    32'h0);
        checkOutput("to_c11_srcready", 32'(srcReady), 32'h0);
        applyStimulus(1'b1, 8'h11);
        waitCycles(1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("to_err_sticky", 32'(err),    32'h1);
        checkOutput("to_err_txdata", 32'(txData), 32'hC3);
        errClr = 1'b1;
        waitCycles(1);
        errClr = 1'b0;
        checkOutput("to_clr_err",      32'(err),      32'h0);
        checkOutput("to_clr_srcready", 32'(srcReady), 32'h1);

        // ---- ack rises on the same cycle the counter reaches TIMEOUT ----
        applyStimulus(1'b1, 8'h3C);
        waitCycles(1);
        applyStimulus(1'b0, 8'h00);
        errClr = 1'b1;
        waitCycles(8);
        ackForce = 1'b1;
        waitCycles(2);
        errClr = 1'b0;
        checkOutput("race_c10_err",   32'(err),   32'h0);
        checkOutput("race_c10_txreq", 32'(txReq), 32'h1);
        waitCycles(1);
        checkOutput("race_c11_txreq", 32'(txReq), 32'h0);
        checkOutput("race_c11_err",   32'(err),   32'h0);
        ackForce = 1'b0;
        waitCycles(2);
        checkOutput("race_pre_done", 32'(done), 32'h0);
        waitCycles(1);
        checkOutput("race_done",     32'(done),     32'h1);
        checkOutput("race_srcready", 32'(srcReady), 32'h1);
        checkOutput("race_txdata",   32'(txData),   32'h3C);
        checkOutput("race_err_end",  32'(err),      32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hs_sync_tx
